rtr_flow_ctrl_input_batch: RTL and testbench
============================================

Name: rtr_flow_ctrl_input_batch

Overview:
Receive-side flow control interface for a router output port. It accepts batched credit messages from the downstream router, where one message returns 1..2^cred_cnt_width credits for one VC. It accumulates the credits in per-VC pending counters and replays them as at most one single-credit event per cycle, in round-robin VC order. This lets downstream routers coalesce credit returns while the router output-VC credit trackers keep their one-event-per-cycle interface.

Parameters:
- num_vcs, 4: number of VCs; must be >= 1.
- cred_cnt_width, 2: width of the count field. The field value c encodes c+1 credits.
- pend_width, 4: width of each per-VC pending counter. Counters saturate at 2^pend_width-1.
- Derived vc_idx_width = clogb(num_vcs); this is 0 when num_vcs==1, and the VC field is then absent.
- Derived flow_ctrl_width = 1 + vc_idx_width + cred_cnt_width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- active  in  1  clock-gating activity hint from the port.
- flow_ctrl_in  in  flow_ctrl_width  incoming message, laid out as [valid | vc_idx | count].
- fc_event_valid_out  out  1  one credit event this cycle.
- fc_event_sel_out_ovc  out  num_vcs  one-hot VC of the event; all zeros when there is no event.
- busy_out  out  1  high when a registered message or any pending count is outstanding.
- ovf_err_out  out  1  sticky: a pending counter saturated.

Behaviour:
- Reset (reset_n low, asynchronous):
  - message register valid bit cleared; pending counters cleared;
  - round-robin pointer set to VC 0; ovf_err_out set to 0;
  - all outputs 0.
  The vc/count fields of the message register are not reset.
- Stage 1 (input register):
  - flow_ctrl_in is registered every cycle in which (active | busy_out) is high.
  - The valid bit must clear the cycle after a message, even when active is low.
- Stage 2 (accumulate and drain), each cycle:
  - Grant: among VCs with pending != 0, pick the first at or after the pointer, wrapping around. Assert fc_event_valid_out and the one-hot select for that VC.
  - Pointer update: on a grant, pointer <= granted VC + 1, wrapping num_vcs-1 -> 0. With no grant the pointer holds.
  - Counter update: pend[v] <= pend[v] - (granted==v) + (msg_valid_q && msg_vc_q==v ? msg_cnt_q+1 : 0).
  - Arithmetic: computed at pend_width+1 bits.
  - Overflow: a result above 2^pend_width-1 is clamped to the maximum and sets ovf_err_out, which stays set until reset.
  - Simultaneous grant and increment on the same VC: both apply in the same cycle.
- busy_out = msg_valid_q | (OR of all pend != 0). It is combinational from registered state.
- Latency (feature off): message at edge N -> registered at N -> counter nonzero after N+1 -> first event visible in cycle N+1..N+2 (the cycle after edge N+1).
- A message with count=k yields exactly k+1 events. The events need not be consecutive when other VCs are pending.
- num_vcs==1:
  - select output is the constant 1'b1 whenever fc_event_valid_out is high;
  - no pointer;
  - same counter behaviour otherwise.
- Reset mid-operation: all pending credits are discarded. No events appear after reset deasserts until a new message arrives.

Optional Feature:
Macro RTR_FC_IN_BYPASS_EN.
- Defined:
  - When msg_valid_q is high and all pending counters are zero, the registered message's VC is granted in the same cycle as msg_valid_q (latency one cycle less).
  - Its counter receives msg_cnt_q (count-1 credits) instead of msg_cnt_q+1.
  - The pointer updates as for a normal grant.
- Undefined: no bypass path; credits always pass through the pending counters.

Test Plan:
1. Reset:
   - Stimulus: reset_n low with flow_ctrl_in toggling.
   - Required: all outputs 0, busy_out 0.
   - Then release reset and drive flow_ctrl_in idle (valid=0) for 5 cycles. Required: no events.
2. Single message:
   - Stimulus: num_vcs=4, one message vc=2, count=3 (4 credits).
   - Required: exactly 4 events, sel=0010, on consecutive cycles.
   - Required first-event cycle: N+2 with the feature off, N+1 with it on.
   - Then busy_out falls.
3. Round-robin interleave:
   - Stimulus: same cycle pair of messages vc=0 cnt=1 and vc=3 cnt=1, delivered back-to-back.
   - Required: events alternate 1000, 0001, 1000, 0001.
   - Required total: 4 events.
4. Simultaneous grant and increment:
   - Stimulus: vc=1 pending=1 being granted while a message vc=1 cnt=0 arrives.
   - Required: pending remains 1, then one more event.
   - Required total: 2 events after the message.
5. Saturation:
   - Stimulus: pend_width=4; 5 messages vc=0 cnt=3 in consecutive cycles (20 credits).
   - Required: counter clamps at 15, ovf_err_out rises and stays high, and at most 15 plus in-flight events are emitted.
   - Stimulus: reset. Required: ovf_err_out clears.
6. Activity gating:
   - Stimulus: active=0 immediately after a message.
   - Required: the valid bit still clears and all credits still drain.
   - Required: busy_out high throughout the drain, then low.

Source files
------------

// File: rtl/rtr_flow_ctrl_input_batch.sv
// Batched credit receiver: registers downstream credit messages, accumulates them per VC
// and replays them as one round-robin credit event per cycle. Optional bypass: RTR_FC_IN_BYPASS_EN.
module rtr_flow_ctrl_input_batch #(
    parameter int num_vcs        = 4,
    parameter int cred_cnt_width = 2,
    parameter int pend_width     = 4,
    localparam int vc_idx_width    = $clog2(num_vcs),
    localparam int flow_ctrl_width = 1 + vc_idx_width + cred_cnt_width
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       active,
    input  logic [flow_ctrl_width-1:0] flow_ctrl_in,
    output logic                       fc_event_valid_out,
    output logic [num_vcs-1:0]         fc_event_sel_out_ovc,
    output logic                       busy_out,
    output logic                       ovf_err_out
);

    localparam int vc_w  = (vc_idx_width > 0) ? vc_idx_width : 1;
    localparam int idx_w = vc_w + 1;
    // Sum width also covers a count field wider than the pending counter.
    localparam int sum_w = ((pend_width > cred_cnt_width) ? pend_width : cred_cnt_width) + 1;
    localparam logic [sum_w-1:0]      sum_one  = sum_w'(1);
    localparam logic [sum_w-1:0]      sum_max  = sum_w'((1 << pend_width) - 1);
    localparam logic [pend_width-1:0] pend_max = pend_width'((1 << pend_width) - 1);

    logic                      msg_valid_q;
    logic [vc_w-1:0]           msg_vc_q;
    logic [cred_cnt_width-1:0] msg_cnt_q;
    logic [pend_width-1:0]     pend_q [num_vcs];
    logic [pend_width-1:0]     pend_d [num_vcs];
    logic [sum_w-1:0]          pend_sum [num_vcs];
    logic [vc_w-1:0]           ptr_q;
    logic [vc_w-1:0]           ptr_d;
    logic                      ovf_q;
    logic                      ovf_hit;
    logic                      load;
    logic                      any_pend;
    logic                      bypass;
    logic                      grant_from_pend;
    logic [vc_w-1:0]           pend_grant_vc;
    logic                      grant_valid;
    logic [vc_w-1:0]           grant_vc;
    logic [idx_w-1:0]          idx_wide;
    logic [vc_w-1:0]           idx;

    assign load = active | busy_out;

    // Message fields carry no reset; only the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (load) begin
            msg_cnt_q <= flow_ctrl_in[cred_cnt_width-1:0];
        end
    end

    generate
        if (num_vcs > 1) begin : g_vc_field
            always_ff @(posedge clk) begin
                if (load) begin
                    msg_vc_q <= flow_ctrl_in[cred_cnt_width +: vc_w];
                end
            end
        end else begin : g_no_vc_field
            assign msg_vc_q = '0;
        end
    endgenerate

    always_comb begin
        any_pend = 1'b0;
        for (int v = 0; v < num_vcs; v++) begin
            if (pend_q[v] != '0) begin
                any_pend = 1'b1;
            end
        end
    end

`ifdef RTR_FC_IN_BYPASS_EN
    assign bypass = msg_valid_q & ~any_pend;
`else
    assign bypass = 1'b0;
`endif

    // Round-robin search starting at the pointer, wrapping past the last VC.
    always_comb begin
        grant_from_pend = 1'b0;
        pend_grant_vc   = '0;
        idx_wide        = '0;
        idx             = '0;
        for (int i = 0; i < num_vcs; i++) begin
            idx_wide = {1'b0, ptr_q} + idx_w'(i);
            if (idx_wide >= idx_w'(num_vcs)) begin
                idx_wide = idx_wide - idx_w'(num_vcs);
            end
            idx = idx_wide[vc_w-1:0];
            if (!grant_from_pend && (pend_q[idx] != '0)) begin
                grant_from_pend = 1'b1;
                pend_grant_vc   = idx;
            end
        end
    end

    assign grant_valid = grant_from_pend | bypass;
    assign grant_vc    = grant_from_pend ? pend_grant_vc : msg_vc_q;

    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid) begin
            if (grant_vc == vc_w'(num_vcs - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_vc + vc_w'(1);
            end
        end
    end

    // A bypassed credit is spent immediately, so the counter takes one credit fewer.
    always_comb begin
        ovf_hit = 1'b0;
        for (int v = 0; v < num_vcs; v++) begin
            pend_sum[v] = sum_w'(pend_q[v]);
            if (grant_from_pend && (pend_grant_vc == vc_w'(v))) begin
                pend_sum[v] = pend_sum[v] - sum_one;
            end
            if (msg_valid_q && (msg_vc_q == vc_w'(v))) begin
                if (bypass) begin
                    pend_sum[v] = pend_sum[v] + sum_w'(msg_cnt_q);
                end else begin
                    pend_sum[v] = pend_sum[v] + sum_w'(msg_cnt_q) + sum_one;
                end
            end
            if (pend_sum[v] > sum_max) begin
                pend_d[v] = pend_max;
                ovf_hit   = 1'b1;
            end else begin
                pend_d[v] = pend_sum[v][pend_width-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msg_valid_q <= 1'b0;
            ptr_q       <= '0;
            ovf_q       <= 1'b0;
            for (int v = 0; v < num_vcs; v++) begin
                pend_q[v] <= '0;
            end
        end else begin
            if (load) begin
                msg_valid_q <= flow_ctrl_in[flow_ctrl_width-1];
            end
            ptr_q <= ptr_d;
            if (ovf_hit) begin
                ovf_q <= 1'b1;
            end
            for (int v = 0; v < num_vcs; v++) begin
                pend_q[v] <= pend_d[v];
            end
        end
    end

    always_comb begin
        fc_event_sel_out_ovc = '0;
        for (int v = 0; v < num_vcs; v++) begin
            fc_event_sel_out_ovc[v] = grant_valid && (grant_vc == vc_w'(v));
        end
    end

    assign fc_event_valid_out = grant_valid;
    assign busy_out           = msg_valid_q | any_pend;
    assign ovf_err_out        = ovf_q;

endmodule

// File: tb/tb_rtr_flow_ctrl_input_batch.sv
// Randomized and directed bench for rtr_flow_ctrl_input_batch against a per-VC credit-pool model.
module tb_rtr_flow_ctrl_input_batch;

    localparam int NV   = 4;
    localparam int VW   = 2;
    localparam int CW   = 2;
    localparam int FW   = 1 + VW + CW;
    localparam int PMAX = 15;
`ifdef RTR_FC_IN_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          active = 1'b0;
    logic [FW-1:0] flow_ctrl_in = '0;
    logic          ev;
    logic [NV-1:0] sel;
    logic          busy;
    logic          ovf;

    rtr_flow_ctrl_input_batch #(
        .num_vcs(NV), .cred_cnt_width(CW), .pend_width(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .active(active), .flow_ctrl_in(flow_ctrl_in),
        .fc_event_valid_out(ev), .fc_event_sel_out_ovc(sel),
        .busy_out(busy), .ovf_err_out(ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: credit pool per VC, the message waiting in the input register, rotating start VC.
    int m_pend [NV];
    int m_ptr;
    bit m_ovf;
    bit m_mv;
    int m_mvc;
    int m_mcnt;

    int evt_cnt;
    int first_tick;
    int last_tick;
    int tick_no = 0;
    int evt_q [$];

    function automatic bit m_any();
        for (int v = 0; v < NV; v++) if (m_pend[v] > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_grant();
        if (m_any()) begin
            for (int i = 0; i < NV; i++) if (m_pend[(m_ptr + i) % NV] > 0) return (m_ptr + i) % NV;
        end
        if (BYP && m_mv) return m_mvc;
        return -1;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) m_pend[v] = 0;
        m_ptr = 0; m_ovf = 0; m_mv = 0; m_mvc = 0; m_mcnt = 0;
    endtask

    task automatic model_step(input bit iv, input int ivc, input int icnt, input bit act);
        int g;
        bit byp;
        bit ld;
        int credits;
        g   = m_grant();
        byp = BYP && m_mv && !m_any();
        ld  = act || m_mv || m_any();
        for (int v = 0; v < NV; v++) begin
            credits = m_pend[v];
            if (g == v && !byp) credits = credits - 1;
            if (m_mv && m_mvc == v) credits = credits + (byp ? m_mcnt : m_mcnt + 1);
            if (credits > PMAX) begin
                credits = PMAX;
                m_ovf = 1'b1;
            end
            m_pend[v] = credits;
        end
        if (g >= 0) m_ptr = (g + 1) % NV;
        if (ld) begin
            m_mv = iv; m_mvc = ivc; m_mcnt = icnt;
        end
    endtask

    task automatic evt_clear();
        evt_cnt = 0; first_tick = -1; last_tick = -1;
        evt_q.delete();
    endtask

    task automatic tick(input bit iv, input int ivc, input int icnt, input bit act);
        logic [1:0] vcb;
        logic [1:0] cb;
        int g;
        vcb = ivc[1:0];
        cb  = icnt[1:0];
        flow_ctrl_in = {iv, vcb, cb};
        active = act;
        @(posedge clk);
        if (reset_n) model_step(iv, ivc, icnt, act);
        @(negedge clk);
        g = m_grant();
        chk("evt_valid", 32'(ev), (g >= 0) ? 1 : 0);
        chk("evt_sel", 32'(sel), (g >= 0) ? (1 << g) : 0);
        chk("busy", 32'(busy), (m_mv || m_any()) ? 1 : 0);
        chk("ovf", 32'(ovf), 32'(m_ovf));
        if (ev === 1'b1) begin
            evt_cnt++;
            if (first_tick < 0) first_tick = tick_no;
            last_tick = tick_no;
            for (int v = 0; v < NV; v++) if (sel[v]) evt_q.push_back(v);
        end
        tick_no++;
    endtask

    task automatic idle(input int n, input bit act);
        for (int i = 0; i < n; i++) tick(1'b0, $urandom_range(0, 3), $urandom_range(0, 3), act);
    endtask

    task automatic apply_reset(input int n);
        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) tick($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
        reset_n = 1'b1;
    endtask

    int start;

    initial begin
        model_reset();
        evt_clear();
        @(negedge clk);

        // Reset with toggling input, then idle
        apply_reset(4);
        chk("rst_ovf", 32'(ovf), 0);
        evt_clear();
        idle(5, 1'b1);
        chk("rst_idle_evts", evt_cnt, 0);

        // Single message: vc=2, 4 credits
        evt_clear();
        start = tick_no;
        tick(1'b1, 2, 3, 1'b1);
        idle(8, 1'b1);
        chk("single_cnt", evt_cnt, 4);
        chk("single_first", first_tick - start, BYP ? 0 : 1);
        chk("single_consec", last_tick - first_tick, 3);
        chk("single_busy_end", 32'(busy), 0);

        // Round-robin interleave of vc0 and vc3
        evt_clear();
        tick(1'b1, 0, 1, 1'b1);
        tick(1'b1, 3, 1, 1'b1);
        idle(6, 1'b1);
        chk("rr_cnt", evt_cnt, 4);
        if (!BYP) begin
            for (int i = 0; i < 4; i++) chk("rr_order", (i < evt_q.size()) ? evt_q[i] : -1, (i % 2 == 0) ? 0 : 3);
        end

        // Grant and increment on the same VC in one cycle
        evt_clear();
        tick(1'b1, 1, 0, 1'b1);
        tick(1'b1, 1, 0, 1'b1);
        idle(5, 1'b1);
        chk("simul_cnt", evt_cnt, 2);

        // Saturation: 6 x 4 credits on vc0, 4 credits lost to clamping
        evt_clear();
        for (int i = 0; i < 6; i++) tick(1'b1, 0, 3, 1'b1);
        chk("sat_ovf_rise", 32'(ovf), 1);
        idle(25, 1'b1);
        chk("sat_cnt", evt_cnt, 20);
        chk("sat_ovf_sticky", 32'(ovf), 1);

        // Reset mid-drain discards pending credits and clears overflow
        tick(1'b1, 2, 3, 1'b1);
        tick(1'b0, 0, 0, 1'b1);
        apply_reset(2);
        chk("midrst_ovf", 32'(ovf), 0);
        evt_clear();
        idle(5, 1'b1);
        chk("midrst_evts", evt_cnt, 0);

        // Activity gating: active drops right after the message
        evt_clear();
        tick(1'b1, 3, 3, 1'b1);
        idle(8, 1'b0);
        chk("gate_cnt", evt_cnt, 4);
        chk("gate_busy_end", 32'(busy), 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 2) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 3) != 0));
        end
        idle(80, 1'b1);
        chk("rand_busy_end", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
